// File: rtl/usb_serial_pkg.sv
// Shared types and constants for the USB CDC serial IN-direction scheduler.
package usb_serial_pkg;

  localparam int USB_FS_MAX_PKT       = 64;
  localparam int DEFAULT_IDLE_TIMEOUT = 48000;  // 1 ms at 48 MHz

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE,
    ST_WAIT_ACK
  } state_e;

endpackage

// File: rtl/usb_serial_idle_timer.sv
// Saturating idle counter; expired is high while the count sits at LIMIT-1.
// Shared by the partial-packet timeout and the zero-length-packet timeout.
module usb_serial_idle_timer #(
  parameter int LIMIT = 48000,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != W'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/usb_serial_in_sched.sv
// IN-direction packet scheduler between the serial byte stream and the usb_fs_pe IN endpoint.
// Optional zero-length-packet generation after full packets: define USB_SERIAL_ZLP_EN.
module usb_serial_in_sched
  import usb_serial_pkg::*;
#(
  parameter int MAX_PKT      = USB_FS_MAX_PKT,
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
  localparam int CNT_W = $clog2(MAX_PKT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tx_free,
  input  logic             tx_put,
  input  logic [7:0]       tx_data,
  input  logic             tx_flush,
  output logic             in_ep_req,
  input  logic             in_ep_grant,
  input  logic             in_ep_data_free,
  output logic             in_ep_data_put,
  output logic [7:0]       in_ep_data,
  output logic             in_ep_data_done,
  output logic             in_ep_stall,
  input  logic             in_ep_acked,
  output logic             busy,
  output state_e           dbg_state,
  output logic [CNT_W-1:0] dbg_byte_cnt
);

  state_e           state, state_next;
  logic [CNT_W-1:0] byte_cnt, cnt_inc;
  logic             flush_pend;
  logic             accept, has_data, close_fill, zlp_start;
  logic             idle_expired, timer_clear, timer_en;

`ifdef USB_SERIAL_ZLP_EN
  logic last_full, zlp_pend;
`endif

  // Byte handshake: a byte moves on every cycle where tx_put and tx_free are both
  // high; the writer holds tx_put/tx_data stable until that cycle.
  always_comb begin
    tx_free = 1'b0;
    if (state == ST_FILL && in_ep_data_free && byte_cnt < CNT_W'(MAX_PKT)) tx_free = 1'b1;
`ifdef USB_SERIAL_ZLP_EN
    if (zlp_pend) tx_free = 1'b0;
`endif
  end

  assign accept   = tx_put && tx_free;
  assign cnt_inc  = byte_cnt + CNT_W'(accept);
  assign has_data = (byte_cnt != '0) || accept;

`ifdef USB_SERIAL_ZLP_EN
  assign zlp_start  = (state == ST_IDLE) && last_full && !tx_put && (tx_flush || idle_expired);
  assign close_fill = (cnt_inc == CNT_W'(MAX_PKT)) || ((tx_flush || flush_pend) && has_data) ||
                      (idle_expired && byte_cnt != '0) || zlp_pend;
  assign timer_en   = (state == ST_FILL) || (state == ST_IDLE && last_full);
`else
  assign zlp_start  = 1'b0;
  assign close_fill = (cnt_inc == CNT_W'(MAX_PKT)) || ((tx_flush || flush_pend) && has_data) ||
                      (idle_expired && byte_cnt != '0);
  assign timer_en   = (state == ST_FILL);
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (tx_put || zlp_start) state_next = ST_REQ;
      ST_REQ:      if (in_ep_grant) state_next = ST_FILL;
      ST_FILL: begin
        if (close_fill)       state_next = ST_DONE;
        else if (!in_ep_grant) state_next = ST_REQ;
      end
      ST_DONE:     state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (in_ep_acked) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A grant drop keeps byte_cnt: those bytes already sit in the endpoint buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (accept) byte_cnt <= cnt_inc;
      else if (state == ST_WAIT_ACK && in_ep_acked) byte_cnt <= '0;

      if (state == ST_REQ && tx_flush) flush_pend <= 1'b1;
      else if (state == ST_FILL && (state_next != ST_FILL || (tx_flush && !has_data)))
        flush_pend <= 1'b0;
    end
  end

`ifdef USB_SERIAL_ZLP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_full <= 1'b0;
      zlp_pend  <= 1'b0;
    end else if (zlp_start) begin
      zlp_pend <= 1'b1;
    end else if (state == ST_WAIT_ACK && in_ep_acked) begin
      zlp_pend  <= 1'b0;
      last_full <= (byte_cnt == CNT_W'(MAX_PKT));
    end
  end
`endif

  assign timer_clear = accept || (state == ST_WAIT_ACK && in_ep_acked) ||
                       (state == ST_IDLE && state_next == ST_REQ);

  usb_serial_idle_timer #(.LIMIT(IDLE_TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (idle_expired)
  );

  assign in_ep_req       = (state != ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign in_ep_data_done = (state == ST_DONE);
  assign in_ep_data_put  = accept;
  assign in_ep_data      = tx_data;
  assign in_ep_stall     = 1'b0;
  assign dbg_state       = state;
  assign dbg_byte_cnt    = byte_cnt;

endmodule
